// File: rtl/ggt_pkg.sv
// Shared ALU command codes, state encoding and widths for the ggT controller and its ALU.
package ggt_pkg;

  localparam int DATA_W = 16;
  localparam int ITER_W = 5;
  localparam logic [ITER_W-1:0] ITER_MAX = 5'd31;

  localparam logic [2:0] GIVE_BACK_BIGGER  = 3'd0;
  localparam logic [2:0] GIVE_BACK_SMALLER = 3'd1;
  localparam logic [2:0] ALU_MODULO        = 3'd2;
  localparam logic [2:0] ALU_IDLE          = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_MAX,
    S_MIN,
    S_MOD_START,
    S_MOD_WAIT,
    S_DONE
  } state_t;

endpackage

// File: rtl/ggt_control_if.sv
// Request/result and ALU-side signals of the ggT controller.
// GGT_ITER_CNT_EN adds the iter_cnt_o modulo-operation counter.
interface ggt_control_if;
  import ggt_pkg::*;

  logic              start_i;
  logic [DATA_W-1:0] zahl_a_i;
  logic [DATA_W-1:0] zahl_b_i;
  logic [2:0]        alu_mode_o;
  logic              modulo_start_o;
  logic [DATA_W-1:0] op_a_o;
  logic [DATA_W-1:0] op_b_o;
  logic [DATA_W-1:0] alu_res_i;
  logic              modulo_ready_i;
  logic              ready_o;
  logic              valid_o;
  logic [DATA_W-1:0] ergebnis_o;
`ifdef GGT_ITER_CNT_EN
  logic [ITER_W-1:0] iter_cnt_o;
`endif

  // Controller side.
  modport slave (
    input  start_i, zahl_a_i, zahl_b_i, alu_res_i, modulo_ready_i,
`ifdef GGT_ITER_CNT_EN
    output iter_cnt_o,
`endif
    output alu_mode_o, modulo_start_o, op_a_o, op_b_o, ready_o, valid_o, ergebnis_o
  );

  // Requester and ALU side.
  modport master (
    output start_i, zahl_a_i, zahl_b_i, alu_res_i, modulo_ready_i,
`ifdef GGT_ITER_CNT_EN
    input  iter_cnt_o,
`endif
    input  alu_mode_o, modulo_start_o, op_a_o, op_b_o, ready_o, valid_o, ergebnis_o
  );

endinterface

// File: rtl/ggt_control.sv
// Euclidean ggT sequencer driving a combinational max/min ALU with a multi-cycle modulo unit.
// Optional GGT_ITER_CNT_EN adds a saturating count of completed modulo operations.
module ggt_control
  import ggt_pkg::*;
(
  input  logic         clk,
  input  logic         rst_i,
  ggt_control_if.slave bus
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;
  logic [DATA_W-1:0] r_big;
  logic [DATA_W-1:0] r_small;
  logic [DATA_W-1:0] r_ergebnis;
  logic              r_wait_first;
  logic [2:0]        w_alu_mode;
  logic              w_mod_start;
  logic              w_ready;
  logic              w_valid;
  logic              w_accept;
  logic              w_ops_zero;
  logic              w_rem_take;
  logic              w_rem_zero;

  assign w_accept   = (r_state == S_IDLE) && bus.start_i;
  assign w_ops_zero = (r_op_a == '0) || (r_op_b == '0);
  // The first wait cycle may still see the previous operation's ready flag.
  assign w_rem_take = (r_state == S_MOD_WAIT) && !r_wait_first && bus.modulo_ready_i;
  assign w_rem_zero = (bus.alu_res_i == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_alu_mode  = ALU_IDLE;
    w_mod_start = 1'b0;
    w_ready     = 1'b0;
    w_valid     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.start_i) w_state_nxt = S_CHECK;
      end
      S_CHECK:     w_state_nxt = w_ops_zero ? S_DONE : S_MAX;
      S_MAX: begin
        w_alu_mode  = GIVE_BACK_BIGGER;
        w_state_nxt = S_MIN;
      end
      S_MIN: begin
        w_alu_mode  = GIVE_BACK_SMALLER;
        w_state_nxt = S_MOD_START;
      end
      S_MOD_START: begin
        w_alu_mode  = ALU_MODULO;
        w_mod_start = 1'b1;
        w_state_nxt = S_MOD_WAIT;
      end
      S_MOD_WAIT: begin
        w_alu_mode = ALU_MODULO;
        if (w_rem_take) w_state_nxt = w_rem_zero ? S_DONE : S_MOD_START;
      end
      S_DONE: begin
        w_valid     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_big        <= '0;
      r_small      <= '0;
      r_ergebnis   <= '0;
      r_wait_first <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (bus.start_i) begin
          r_op_a <= bus.zahl_a_i;
          r_op_b <= bus.zahl_b_i;
        end
        S_CHECK: if (w_ops_zero) r_ergebnis <= r_op_a | r_op_b;
        S_MAX:   r_big <= bus.alu_res_i;
        S_MIN: begin
          r_small <= bus.alu_res_i;
          r_op_a  <= r_big;
          r_op_b  <= bus.alu_res_i;
        end
        S_MOD_START: r_wait_first <= 1'b1;
        S_MOD_WAIT: begin
          r_wait_first <= 1'b0;
          if (w_rem_take) begin
            if (w_rem_zero) begin
              r_ergebnis <= r_small;
            end else begin
              r_big   <= r_small;
              r_small <= bus.alu_res_i;
              r_op_a  <= r_small;
              r_op_b  <= bus.alu_res_i;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GGT_ITER_CNT_EN
  logic [ITER_W-1:0] r_iter_cnt;

  always_ff @(posedge clk) begin
    if (rst_i)                                     r_iter_cnt <= '0;
    else if (w_accept)                             r_iter_cnt <= '0;
    else if (w_rem_take && r_iter_cnt != ITER_MAX) r_iter_cnt <= r_iter_cnt + 5'd1;
  end

  assign bus.iter_cnt_o = r_iter_cnt;
`endif

  assign bus.alu_mode_o     = w_alu_mode;
  assign bus.modulo_start_o = w_mod_start;
  assign bus.op_a_o         = r_op_a;
  assign bus.op_b_o         = r_op_b;
  assign bus.ready_o        = w_ready;
  assign bus.valid_o        = w_valid;
  assign bus.ergebnis_o     = r_ergebnis;

endmodule

// File: tb/tb_ggt_control.sv
// Self-checking bench for ggt_control: behavioural ALU, Euclid reference model, random and directed runs.
module tb_ggt_control;
  import ggt_pkg::*;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  ggt_control_if bus ();

  ggt_control u_dut (
    .clk   (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          alu_cnt  = 0;
  logic [15:0] alu_rem  = '0;
  int          alu_delay = 2;
  bit          alu_stale = 1'b0;
  int          mod_pulses = 0;
  logic [31:0] obs_ops[$];
  logic [31:0] exp_ops[$];

  // Bench ALU: max/min are combinational; modulo reports ready alu_delay cycles after the start cycle
  // and holds it until the next start. With alu_stale it also flags a bogus zero in the first wait cycle.
  always @(posedge clk) begin
    if (bus.modulo_start_o) begin
      alu_cnt <= 1;
      alu_rem <= (bus.op_b_o == 16'd0) ? 16'd0 : bus.op_a_o % bus.op_b_o;
    end else if (alu_cnt != 0 && alu_cnt < 1000) begin
      alu_cnt <= alu_cnt + 1;
    end
  end

  always_comb begin
    bus.modulo_ready_i = (alu_cnt != 0 && alu_cnt >= alu_delay) || (alu_stale && alu_cnt == 1);
    case (bus.alu_mode_o)
      3'd0:    bus.alu_res_i = (bus.op_a_o > bus.op_b_o) ? bus.op_a_o : bus.op_b_o;
      3'd1:    bus.alu_res_i = (bus.op_a_o < bus.op_b_o) ? bus.op_a_o : bus.op_b_o;
      3'd2: begin
        if (alu_stale && alu_cnt == 1)  bus.alu_res_i = 16'd0;
        else if (bus.modulo_ready_i)    bus.alu_res_i = alu_rem;
        else                            bus.alu_res_i = 16'hFFFF;
      end
      default: bus.alu_res_i = 16'd0;
    endcase
  end

  always @(negedge clk) begin
    if (bus.modulo_start_o) begin
      mod_pulses <= mod_pulses + 1;
      obs_ops.push_back({bus.op_a_o, bus.op_b_o});
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Euclid on plain integers: records the (big, small) pair handed to every modulo operation.
  task automatic gcd_model(input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] g, output int nmod);
    int x, y, r;
    exp_ops.delete();
    nmod = 0;
    if (a == 16'd0 || b == 16'd0) begin
      g = a | b;
      return;
    end
    x = (a > b) ? int'(a) : int'(b);
    y = (a > b) ? int'(b) : int'(a);
    forever begin
      exp_ops.push_back({x[15:0], y[15:0]});
      r = x % y;
      nmod++;
      if (r == 0) break;
      x = y;
      y = r;
    end
    g = y[15:0];
  endtask

  task automatic check_reset(input string tag);
    check({tag, " mode"},   32'(bus.alu_mode_o), 32'd3);
    check({tag, " mstart"}, 32'(bus.modulo_start_o), 32'd0);
    check({tag, " valid"},  32'(bus.valid_o), 32'd0);
    check({tag, " ergeb"},  32'(bus.ergebnis_o), 32'd0);
    check({tag, " op_a"},   32'(bus.op_a_o), 32'd0);
    check({tag, " op_b"},   32'(bus.op_b_o), 32'd0);
    check({tag, " ready"},  32'(bus.ready_o), 32'd1);
`ifdef GGT_ITER_CNT_EN
    check({tag, " iter"},   32'(bus.iter_cnt_o), 32'd0);
`endif
  endtask

  task automatic run_gcd(input logic [15:0] a, input logic [15:0] b, input int dly,
                         input bit stale, input bit hold, input string tag);
    logic [15:0] g;
    int nmod, cyc, rdy_bad, base_p, base_o, exp_lat;
    bit got;
    gcd_model(a, b, g, nmod);
    // Per iteration: start cycle, ignored first wait, then Tmod = dly-1 further wait cycles.
    exp_lat = (nmod == 0) ? 2 : 4 + nmod * (2 + (dly - 1));
    alu_delay = dly;
    alu_stale = stale;
    cyc = 0;
    while (!bus.ready_o && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " ready_in"}, 32'(bus.ready_o), 32'd1);
    base_p = mod_pulses;
    base_o = obs_ops.size();
    bus.start_i  = 1'b1;
    bus.zahl_a_i = a;
    bus.zahl_b_i = b;
    @(negedge clk);
    cyc = 1;
    if (!hold) bus.start_i = 1'b0;
    got = 1'b0;
    rdy_bad = 0;
    while (cyc < 3000) begin
      if (bus.valid_o) begin
        got = 1'b1;
        break;
      end
      if (bus.ready_o) rdy_bad++;
      @(negedge clk);
      cyc++;
    end
    bus.start_i = 1'b0;
    check({tag, " done"}, 32'(got), 32'd1);
    check({tag, " result"}, 32'(bus.ergebnis_o), 32'(g));
    check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, " busy_ready"}, 32'(rdy_bad), 32'd0);
    check({tag, " mod_ops"}, 32'(mod_pulses - base_p), 32'(nmod));
    for (int i = 0; i < nmod && base_o + i < obs_ops.size(); i++)
      check({tag, $sformatf(" ops%0d", i)}, obs_ops[base_o + i], exp_ops[i]);
`ifdef GGT_ITER_CNT_EN
    check({tag, " iter"}, 32'(bus.iter_cnt_o), 32'((nmod > 31) ? 31 : nmod));
`endif
    @(negedge clk);
    check({tag, " valid_1cyc"}, 32'(bus.valid_o), 32'd0);
    check({tag, " ready_back"}, 32'(bus.ready_o), 32'd1);
    check({tag, " held"}, 32'(bus.ergebnis_o), 32'(g));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc, bad;
    logic [15:0] ra, rb;
    rst_i        = 1'b1;
    bus.start_i  = 1'b0;
    bus.zahl_a_i = '0;
    bus.zahl_b_i = '0;
    repeat (2) @(negedge clk);
    check_reset("por");
    rst_i = 1'b0;

    run_gcd(16'd48, 16'd18, 3, 1'b0, 1'b0, "g48_18");
    run_gcd(16'd0, 16'd7, 2, 1'b0, 1'b0, "g0_7");
    run_gcd(16'd0, 16'd0, 2, 1'b0, 1'b0, "g0_0");
    run_gcd(16'd17, 16'd5, 2, 1'b0, 1'b0, "g17_5");
    run_gcd(16'd5, 16'd17, 2, 1'b0, 1'b0, "g5_17");
    run_gcd(16'd250, 16'd250, 4, 1'b0, 1'b0, "equal");
    run_gcd(16'd46368, 16'd28657, 2, 1'b0, 1'b1, "fib");

    // Reset in the first MOD_WAIT cycle of a 48/18 run; the late ALU ready must be ignored.
    alu_delay = 4;
    alu_stale = 1'b0;
    bus.start_i  = 1'b1;
    bus.zahl_a_i = 16'd48;
    bus.zahl_b_i = 16'd18;
    @(negedge clk);
    bus.start_i = 1'b0;
    cyc = 0;
    while (!bus.modulo_start_o && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("rst reach_mod", 32'(bus.modulo_start_o), 32'd1);
    @(negedge clk);
    check("rst in_wait", 32'(bus.alu_mode_o), 32'd2);
    rst_i = 1'b1;
    @(negedge clk);
    check_reset("midrst");
    rst_i = 1'b0;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.valid_o || !bus.ready_o || bus.modulo_start_o) bad++;
    end
    check("late_ready_ignored", 32'(bad), 32'd0);
    run_gcd(16'd9, 16'd6, 3, 1'b0, 1'b0, "after_rst");

    run_gcd(16'd12, 16'd8, 2, 1'b1, 1'b0, "stale");
    run_gcd(16'd1071, 16'd462, 3, 1'b1, 1'b0, "stale2");

    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 3) == 0) ra = 16'($urandom_range(0, 20));
      else                           ra = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) == 0) rb = 16'($urandom_range(0, 20));
      else                           rb = 16'($urandom_range(0, 65535));
      run_gcd(ra, rb, int'($urandom_range(2, 5)), bit'($urandom_range(0, 1)), 1'b0,
              $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
